// File: rtl/tp_requester.sv
// tp_requester: initiator side of the two-operand sum responder.
// Latches an operand pair, holds it on req_in1/req_in2 for a fixed LAT-cycle
// window, samples rsp_out once and offers it on a valid/ready result port.
// Timing never depends on operand values.
// Optional feature macro: TP_REQUESTER_CHECK_EN (sticky sum check on err).
module tp_requester #(
  parameter int W   = 2,
  parameter int LAT = 2,   // legal 1..15
  parameter int CW  = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [W-1:0]  cmd_a,
  input  logic [W-1:0]  cmd_b,
  output logic [W-1:0]  req_in1,
  output logic [W-1:0]  req_in2,
  input  logic [W-1:0]  rsp_out,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [W-1:0]  res_data,
  output logic          busy,
  output logic [CW-1:0] done_cnt,
  output logic          err
);

  localparam int CNTW = 4;
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(LAT - 1);

  typedef enum logic [1:0] {IDLE, DRIVE, CAPTURE, HOLD} state_e;

  state_e          state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [W-1:0]    in1_q, in1_d, in2_q, in2_d, res_q, res_d;
  logic            rdy_q, rdy_d, vld_q, vld_d, busy_q, busy_d;
  logic [CW-1:0]   done_q, done_d;

  logic accept, complete;

  // handshakes use the registered flags so they match what the ports show
  assign accept   = cmd_valid & rdy_q;
  assign complete = vld_q & res_ready;

  // next-state, operand hold, capture and counters
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    in1_d   = in1_q;
    in2_d   = in2_q;
    res_d   = res_q;
    done_d  = done_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          in1_d   = cmd_a;
          in2_d   = cmd_b;
          cnt_d   = '0;
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        // fixed-length wait; no early exit on any data value
        if (cnt_q == CNT_LAST) state_d = CAPTURE;
        else                   cnt_d   = cnt_q + 1'b1;
      end
      CAPTURE: begin
        res_d   = rsp_out;
        state_d = HOLD;
      end
      HOLD: begin
        if (complete) begin
          done_d  = done_q + 1'b1;
          in1_d   = '0;
          in2_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // status flags are registered copies of the next state
    rdy_d  = (state_d == IDLE);
    vld_d  = (state_d == HOLD);
    busy_d = (state_d != IDLE);
  end

  // state registers; reset abandons any transaction in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      in1_q   <= '0;
      in2_q   <= '0;
      res_q   <= '0;
      done_q  <= '0;
      rdy_q   <= 1'b1;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      in1_q   <= in1_d;
      in2_q   <= in2_d;
      res_q   <= res_d;
      done_q  <= done_d;
      rdy_q   <= rdy_d;
      vld_q   <= vld_d;
      busy_q  <= busy_d;
    end
  end

`ifdef TP_REQUESTER_CHECK_EN
  logic [W-1:0] sum_exp;
  logic         err_q, err_d;

  assign sum_exp = in1_q + in2_q;

  // sticky compare of the sampled response against the held operands
  always_comb begin
    err_d = err_q;
    if (state_q == CAPTURE && rsp_out != sum_exp) err_d = 1'b1;
  end

  // err flop, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign cmd_ready = rdy_q;
  assign res_valid = vld_q;
  assign busy      = busy_q;
  assign req_in1   = in1_q;
  assign req_in2   = in2_q;
  assign res_data  = res_q;
  assign done_cnt  = done_q;

endmodule
